// File: rtl/reorder_buffer_mp_pkg.sv
// Shared definitions for the multi-port reorder buffer: entry type encodings,
// default geometry and small type-classification helpers.
package reorder_buffer_mp_pkg;

  localparam int unsigned ROB_TYPE_W   = 2;
  localparam int unsigned ROB_AW_DEF   = 4;
  localparam int unsigned WB_PORTS_DEF = 2;
  localparam int unsigned XLEN_DEF     = 32;

  typedef enum logic [ROB_TYPE_W-1:0] {
    ROB_T_REG    = 2'd0,
    ROB_T_STORE  = 2'd1,
    ROB_T_BRANCH = 2'd2,
    ROB_T_JALR   = 2'd3
  } rob_type_e;

  function automatic logic rob_writes_rd(rob_type_e t);
    return (t == ROB_T_REG) || (t == ROB_T_JALR);
  endfunction

  function automatic logic rob_resolves_pc(rob_type_e t);
    return (t == ROB_T_BRANCH) || (t == ROB_T_JALR);
  endfunction

endpackage

// File: rtl/reorder_buffer_mp_query.sv
// Operand lookup for one id: stored result first, otherwise the lowest-index
// writeback port carrying a result for that busy entry this cycle.
module rob_query_port
  import reorder_buffer_mp_pkg::*;
#(
  parameter int unsigned ROB_AW   = ROB_AW_DEF,
  parameter int unsigned WB_PORTS = WB_PORTS_DEF,
  parameter int unsigned XLEN     = XLEN_DEF
) (
  input  logic [ROB_AW-1:0]                     q_id_i,
  input  logic [(1<<ROB_AW)-1:0]                busy_i,
  input  logic [(1<<ROB_AW)-1:0]                ready_i,
  input  logic [(1<<ROB_AW)-1:0][XLEN-1:0]      value_i,
  input  logic [WB_PORTS-1:0]                   wb_valid_i,
  input  logic [WB_PORTS*ROB_AW-1:0]            wb_id_i,
  input  logic [WB_PORTS*XLEN-1:0]              wb_value_i,
  output logic                                  q_ready_o,
  output logic [XLEN-1:0]                       q_value_o
);

  logic            hit;
  logic [XLEN-1:0] hit_value;

  always_comb begin
    hit       = 1'b0;
    hit_value = '0;
    if (busy_i[q_id_i]) begin
      if (ready_i[q_id_i]) begin
        hit       = 1'b1;
        hit_value = value_i[q_id_i];
      end else begin
        for (int unsigned p = 0; p < WB_PORTS; p++) begin
          if (!hit && wb_valid_i[p] && (wb_id_i[p*ROB_AW +: ROB_AW] == q_id_i)) begin
            hit       = 1'b1;
            hit_value = wb_value_i[p*XLEN +: XLEN];
          end
        end
      end
    end
  end

  assign q_ready_o = hit;
  assign q_value_o = hit_value;

endmodule

// File: rtl/reorder_buffer_mp.sv
// In-order-commit reorder buffer with N writeback ports, store release and
// branch/JALR mispredict flush. Define ROB_STATS_EN to add commit/flush counters.
module reorder_buffer_mp
  import reorder_buffer_mp_pkg::*;
#(
  parameter int unsigned ROB_AW   = ROB_AW_DEF,
  parameter int unsigned WB_PORTS = WB_PORTS_DEF,
  parameter int unsigned XLEN     = XLEN_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rdy,
  input  logic                         alloc_valid,
  input  logic [ROB_TYPE_W-1:0]        alloc_type,
  input  logic [4:0]                   alloc_rd,
  input  logic [XLEN-1:0]              alloc_pc,
  input  logic [XLEN-1:0]              alloc_pred_pc,
  output logic                         alloc_ready,
  output logic [ROB_AW-1:0]            alloc_id,
  input  logic [WB_PORTS-1:0]          wb_valid,
  input  logic [WB_PORTS*ROB_AW-1:0]   wb_id,
  input  logic [WB_PORTS*XLEN-1:0]     wb_value,
  input  logic [WB_PORTS*XLEN-1:0]     wb_target,
  input  logic [2*ROB_AW-1:0]          q_id,
  output logic [1:0]                   q_ready,
  output logic [2*XLEN-1:0]            q_value,
  output logic                         commit_valid,
  output logic                         commit_reg,
  output logic [4:0]                   commit_rd,
  output logic [XLEN-1:0]              commit_value,
  output logic [ROB_AW-1:0]            commit_id,
  output logic                         commit_store,
  output logic                         flush,
  output logic [XLEN-1:0]              flush_pc,
  output logic [ROB_AW-1:0]            head_id
`ifdef ROB_STATS_EN
  ,
  output logic [31:0]                  stat_commits,
  output logic [31:0]                  stat_flushes
`endif
);

  localparam int unsigned DEPTH = 1 << ROB_AW;

  logic [ROB_AW-1:0]            head_q, head_d, tail_q, tail_d;
  logic [ROB_AW:0]              count_q, count_d;
  logic [DEPTH-1:0]             busy_q, busy_d, ready_q, ready_d;
  logic                         flush_q, flush_d;
  logic [XLEN-1:0]              flush_pc_q, flush_pc_d;

  rob_type_e                    type_q   [DEPTH];
  logic [4:0]                   rd_q     [DEPTH];
  logic [XLEN-1:0]              pred_q   [DEPTH];
  logic [XLEN-1:0]              target_q [DEPTH];
  logic [DEPTH-1:0][XLEN-1:0]   value_q;

  logic                         active, full, alloc_fire, commit_fire, mispredict;
  rob_type_e                    head_type;
  logic [DEPTH-1:0]             wb_we;
  logic [DEPTH-1:0][XLEN-1:0]   wb_val, wb_tgt;
  logic                         unused_pc;

  // The pc travels with the instruction for debug only; nothing here consumes it.
  assign unused_pc = ^alloc_pc;

  assign active      = rdy && !flush_q;
  assign full        = (count_q == (ROB_AW+1)'(DEPTH));
  assign alloc_ready = !full;
  assign alloc_fire  = alloc_valid && alloc_ready && active;
  assign alloc_id    = tail_q;
  assign head_id     = head_q;
  assign head_type   = type_q[head_q];
  assign commit_fire = active && busy_q[head_q] && ready_q[head_q];
  assign mispredict  = commit_fire && rob_resolves_pc(head_type) &&
                       (target_q[head_q] != pred_q[head_q]);

  assign commit_valid = commit_fire;
  assign commit_reg   = commit_fire && rob_writes_rd(head_type) && (rd_q[head_q] != 5'd0);
  assign commit_store = commit_fire && (head_type == ROB_T_STORE);
  assign commit_rd    = commit_fire ? rd_q[head_q]    : '0;
  assign commit_value = commit_fire ? value_q[head_q] : '0;
  assign commit_id    = commit_fire ? head_q          : '0;
  assign flush        = flush_q;
  assign flush_pc     = flush_pc_q;

  // Per-entry writeback select; scanning ports upward lets the lowest index win.
  always_comb begin
    wb_we  = '0;
    wb_val = '0;
    wb_tgt = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      for (int unsigned p = 0; p < WB_PORTS; p++) begin
        if (!wb_we[i] && wb_valid[p] && busy_q[i] &&
            (wb_id[p*ROB_AW +: ROB_AW] == ROB_AW'(i))) begin
          wb_we[i]  = 1'b1;
          wb_val[i] = wb_value[p*XLEN +: XLEN];
          wb_tgt[i] = wb_target[p*XLEN +: XLEN];
        end
      end
    end
  end

  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    busy_d     = busy_q;
    ready_d    = ready_q;
    flush_d    = flush_q;
    flush_pc_d = flush_pc_q;
    if (rdy) begin
      if (flush_q) begin
        head_d  = '0;
        tail_d  = '0;
        count_d = '0;
        busy_d  = '0;
        ready_d = '0;
        flush_d = 1'b0;
      end else begin
        ready_d = ready_q | wb_we;
        if (alloc_fire) begin
          busy_d[tail_q]  = 1'b1;
          ready_d[tail_q] = 1'b0;
          tail_d          = tail_q + 1'b1;
        end
        // Retirement is applied last so a stray writeback cannot re-arm a freed slot.
        if (commit_fire) begin
          busy_d[head_q]  = 1'b0;
          ready_d[head_q] = 1'b0;
          head_d          = head_q + 1'b1;
        end
        case ({alloc_fire, commit_fire})
          2'b10:   count_d = count_q + 1'b1;
          2'b01:   count_d = count_q - 1'b1;
          default: count_d = count_q;
        endcase
        if (mispredict) begin
          flush_d    = 1'b1;
          flush_pc_d = target_q[head_q];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      busy_q     <= '0;
      ready_q    <= '0;
      flush_q    <= 1'b0;
      flush_pc_q <= '0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      busy_q     <= busy_d;
      ready_q    <= ready_d;
      flush_q    <= flush_d;
      flush_pc_q <= flush_pc_d;
    end
  end

  // Payload storage is qualified by busy/ready, so it needs no reset.
  always_ff @(posedge clk) begin
    if (active) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (wb_we[i]) begin
          value_q[i]  <= wb_val[i];
          target_q[i] <= wb_tgt[i];
        end
      end
      if (alloc_fire) begin
        type_q[tail_q] <= rob_type_e'(alloc_type);
        rd_q[tail_q]   <= alloc_rd;
        pred_q[tail_q] <= alloc_pred_pc;
      end
    end
  end

  for (genvar k = 0; k < 2; k++) begin : g_query
    rob_query_port #(
      .ROB_AW   (ROB_AW),
      .WB_PORTS (WB_PORTS),
      .XLEN     (XLEN)
    ) u_query (
      .q_id_i     (q_id[k*ROB_AW +: ROB_AW]),
      .busy_i     (busy_q),
      .ready_i    (ready_q),
      .value_i    (value_q),
      .wb_valid_i (wb_valid),
      .wb_id_i    (wb_id),
      .wb_value_i (wb_value),
      .q_ready_o  (q_ready[k]),
      .q_value_o  (q_value[k*XLEN +: XLEN])
    );
  end

`ifdef ROB_STATS_EN
  logic [31:0] stat_commits_q, stat_flushes_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_commits_q <= '0;
      stat_flushes_q <= '0;
    end else if (rdy) begin
      if (commit_fire) stat_commits_q <= stat_commits_q + 32'd1;
      if (mispredict)  stat_flushes_q <= stat_flushes_q + 32'd1;
    end
  end

  assign stat_commits = stat_commits_q;
  assign stat_flushes = stat_flushes_q;
`endif

endmodule

// File: tb/tb_reorder_buffer_mp.sv
// Directed bench for reorder_buffer_mp: stimulus pushes expected commits/flushes
// into queues and a negedge monitor pops and compares them.
module tb_reorder_buffer_mp;
  import reorder_buffer_mp_pkg::*;

  logic        clk = 1'b0;
  logic        rst, rdy;
  logic        alloc_valid;
  logic [1:0]  alloc_type;
  logic [4:0]  alloc_rd;
  logic [31:0] alloc_pc, alloc_pred_pc;
  logic        alloc_ready;
  logic [3:0]  alloc_id;
  logic [1:0]  wb_valid;
  logic [7:0]  wb_id;
  logic [63:0] wb_value, wb_target;
  logic [7:0]  q_id;
  logic [1:0]  q_ready;
  logic [63:0] q_value;
  logic        commit_valid, commit_reg, commit_store, flush;
  logic [4:0]  commit_rd;
  logic [31:0] commit_value, flush_pc;
  logic [3:0]  commit_id, head_id;
`ifdef ROB_STATS_EN
  logic [31:0] stat_commits, stat_flushes;
`endif

  reorder_buffer_mp #(.ROB_AW(4), .WB_PORTS(2), .XLEN(32)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .alloc_valid(alloc_valid), .alloc_type(alloc_type), .alloc_rd(alloc_rd),
    .alloc_pc(alloc_pc), .alloc_pred_pc(alloc_pred_pc),
    .alloc_ready(alloc_ready), .alloc_id(alloc_id),
    .wb_valid(wb_valid), .wb_id(wb_id), .wb_value(wb_value), .wb_target(wb_target),
    .q_id(q_id), .q_ready(q_ready), .q_value(q_value),
    .commit_valid(commit_valid), .commit_reg(commit_reg), .commit_rd(commit_rd),
    .commit_value(commit_value), .commit_id(commit_id), .commit_store(commit_store),
    .flush(flush), .flush_pc(flush_pc), .head_id(head_id)
`ifdef ROB_STATS_EN
    , .stat_commits(stat_commits), .stat_flushes(stat_flushes)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  id;
    logic        is_reg;
    logic [4:0]  rd;
    logic [31:0] value;
    logic        store;
  } exp_commit_t;

  exp_commit_t cq[$];
  logic [31:0] fq[$];
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic push_c(input int id, input logic r, input int rd, input logic [31:0] v, input logic st);
    exp_commit_t e;
    e.id = 4'(id); e.is_reg = r; e.rd = 5'(rd); e.value = v; e.store = st;
    cq.push_back(e);
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_alloc(input logic v, input logic [1:0] t, input int rd, input logic [31:0] pc, input logic [31:0] pred);
    alloc_valid = v; alloc_type = t; alloc_rd = 5'(rd); alloc_pc = pc; alloc_pred_pc = pred;
  endtask

  task automatic wb0(input int id, input logic [31:0] v);
    wb_valid = 2'b01; wb_id = {4'd0, 4'(id)}; wb_value = {32'd0, v}; wb_target = {32'd0, v};
  endtask

  // Monitor: every commit/flush the DUT presents must match the head of its queue.
  initial begin : monitor
    exp_commit_t e;
    logic [31:0] fexp;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (commit_valid) begin
          checks++;
          if (cq.size() == 0) begin
            failures++;
            $display("FAIL unexpected_commit actual id=%0d required no commit", commit_id);
          end else begin
            e = cq.pop_front();
            if ({commit_id, commit_reg, commit_rd, commit_value, commit_store} !==
                {e.id, e.is_reg, e.rd, e.value, e.store}) begin
              failures++;
              $display("FAIL commit actual id=%0d reg=%0d rd=%0d val=%0h st=%0d required id=%0d reg=%0d rd=%0d val=%0h st=%0d",
                       commit_id, commit_reg, commit_rd, commit_value, commit_store,
                       e.id, e.is_reg, e.rd, e.value, e.store);
            end
          end
        end
        if (flush) begin
          checks++;
          if (fq.size() == 0) begin
            failures++;
            $display("FAIL unexpected_flush actual pc=%0h required no flush", flush_pc);
          end else begin
            fexp = fq.pop_front();
            if (flush_pc !== fexp) begin
              failures++;
              $display("FAIL flush_pc actual=%0h required=%0h", flush_pc, fexp);
            end
          end
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    rst = 1'b1; rdy = 1'b1;
    set_alloc(1'b0, ROB_T_REG, 0, 32'd0, 32'd0);
    wb_valid = '0; wb_id = '0; wb_value = '0; wb_target = '0; q_id = '0;
    #3;
    chk("rst_alloc_ready", alloc_ready, 1);
    chk("rst_alloc_id", alloc_id, 0);
    chk("rst_commit_valid", commit_valid, 0);
    chk("rst_flush", {flush, flush_pc}, 0);
    chk("rst_head", head_id, 0);
    chk("rst_query", {q_ready, q_value}, 0);
    step();
    rst = 1'b0;

    // Fill all 16 slots without writeback.
    for (int i = 0; i < 16; i++) begin
      set_alloc(1'b1, ROB_T_REG, i + 1, 32'h1000 + 32'(4 * i), 32'h1004 + 32'(4 * i));
      mid();
      chk("fill_ready", alloc_ready, 1);
      chk("fill_id", alloc_id, 64'(i));
      step();
    end
    set_alloc(1'b1, ROB_T_REG, 31, 32'h2000, 32'h2004);
    mid(); chk("full_ready", alloc_ready, 0);
    step();
    wb0(0, 32'h1000); push_c(0, 1, 1, 32'h1000, 0);
    mid(); chk("full_hold", alloc_ready, 0);
    step();
    // Commit at full while an alloc is attempted: alloc must be rejected.
    wb0(1, 32'h1001); push_c(1, 1, 2, 32'h1001, 0);
    mid(); chk("full_commit_ready", alloc_ready, 0);
    step();
    // Alloc and commit together at full-1.
    wb_valid = '0;
    set_alloc(1'b1, ROB_T_REG, 20, 32'h3000, 32'h3004);
    mid(); chk("fm1_ready", alloc_ready, 1); chk("fm1_id", alloc_id, 0);
    step();
    alloc_valid = 1'b0;
    mid(); chk("fm1_count_same", alloc_ready, 1);
    step();
    for (int i = 2; i < 16; i++) begin
      wb0(i, 32'h1000 + 32'(i)); push_c(i, 1, i + 1, 32'h1000 + 32'(i), 0);
      step();
    end
    wb_valid = '0;
    for (int j = 1; j < 4; j++) begin
      set_alloc(1'b1, ROB_T_REG, 20 + j, 32'h3000, 32'h3004);
      mid(); chk("wrap_alloc_id", alloc_id, 64'(j));
      step();
    end
    alloc_valid = 1'b0;
    for (int j = 0; j < 4; j++) begin
      wb0(j, 32'h2000 + 32'(j)); push_c(j, 1, 20 + j, 32'h2000 + 32'(j), 0);
      step();
    end
    wb_valid = '0;
    repeat (3) step();
    mid();
    chk("wrap_drained", cq.size(), 0);
    chk("wrap_head", head_id, 4);
    chk("wrap_empty_ready", alloc_ready, 1);
    step();

    // Reset mid-stream, then the dual-writeback and query checks.
    rst = 1'b1; #2;
    chk("rst2_head", head_id, 0);
    rst = 1'b0;
    step();
    for (int i = 0; i < 6; i++) begin
      set_alloc(1'b1, ROB_T_REG, i + 1, 32'h4000, 32'h4004);
      step();
    end
    alloc_valid = 1'b0;
    wb_valid = 2'b11; wb_id = {4'd5, 4'd3};
    wb_value = {32'h22, 32'h11}; wb_target = wb_value;
    q_id = {4'd3, 4'd5};
    mid();
    chk("dual_q_ready", q_ready, 2'b11);
    chk("dual_q0_bypass", q_value[31:0], 32'h22);
    chk("dual_q1_bypass", q_value[63:32], 32'h11);
    step();
    wb_id = {4'd0, 4'd0}; wb_value = {32'hB0, 32'hA0}; wb_target = wb_value;
    q_id = {4'd0, 4'd3};
    push_c(0, 1, 1, 32'hA0, 0); push_c(1, 1, 2, 32'h31, 0); push_c(2, 1, 3, 32'h32, 0);
    push_c(3, 1, 4, 32'h11, 0); push_c(4, 1, 5, 32'h44, 0); push_c(5, 1, 6, 32'h22, 0);
    mid();
    chk("q_stored_ready", q_ready, 2'b11);
    chk("q_stored_value", q_value[31:0], 32'h11);
    chk("q_lowest_port", q_value[63:32], 32'hA0);
    step();
    wb_id = {4'd2, 4'd1}; wb_value = {32'h32, 32'h31}; wb_target = wb_value;
    q_id = {4'd4, 4'd0};
    mid();
    chk("q_not_ready", q_ready, 2'b01);
    chk("q_not_ready_val", q_value, {32'd0, 32'hA0});
    step();
    wb0(4, 32'h44);
    step();
    wb_valid = '0;
    repeat (5) step();
    mid(); chk("dual_drained", cq.size(), 0);
    step();

    // Branch mispredict: commit followed by a one-cycle flush.
    set_alloc(1'b1, ROB_T_BRANCH, 0, 32'h100, 32'h104);
    mid(); chk("br_id", alloc_id, 6);
    step();
    set_alloc(1'b1, ROB_T_REG, 9, 32'h104, 32'h108);
    mid(); chk("br_next_id", alloc_id, 7);
    step();
    alloc_valid = 1'b0;
    wb0(6, 32'h200); push_c(6, 0, 0, 32'h200, 0); fq.push_back(32'h200);
    step();
    wb_valid = '0;
    step();
    set_alloc(1'b1, ROB_T_REG, 10, 32'h200, 32'h204);
    mid(); chk("flush_seen", flush, 1);
    step();
    alloc_valid = 1'b0;
    mid();
    chk("post_flush", flush, 0);
    chk("post_flush_head", head_id, 0);
    chk("post_flush_tail", alloc_id, 0);
    chk("post_flush_ready", alloc_ready, 1);
    chk("flush_drained", cq.size() + fq.size(), 0);
    step();

    // Store release and a three-cycle global stall.
    set_alloc(1'b1, ROB_T_STORE, 3, 32'h300, 32'h304);
    step();
    alloc_valid = 1'b0;
    wb0(0, 32'h55);
    step();
    wb_valid = '0;
    rdy = 1'b0;
    set_alloc(1'b1, ROB_T_REG, 4, 32'h304, 32'h308);
    for (int s = 0; s < 3; s++) begin
      mid();
      chk("stall_no_store", commit_store, 0);
      chk("stall_head", head_id, 0);
      chk("stall_tail", alloc_id, 1);
      step();
    end
    rdy = 1'b1; alloc_valid = 1'b0;
    push_c(0, 0, 3, 32'h55, 1);
    mid(); chk("store_commit", {commit_store, commit_reg}, 2'b10);
    step();
    mid();
    chk("store_one_cycle", commit_store, 0);
    chk("stall_alloc_ignored", alloc_id, 1);
    step();

    // Async reset while a flush is pending discards it.
    set_alloc(1'b1, ROB_T_BRANCH, 0, 32'h310, 32'h300);
    step();
    alloc_valid = 1'b0;
    wb0(1, 32'h400); push_c(1, 0, 0, 32'h400, 0);
    step();
    wb_valid = '0;
    step();
    chk("pending_flush", flush, 1);
    rst = 1'b1; #1;
    chk("rst_kills_flush", {flush, flush_pc}, 0);
    chk("rst3_head", head_id, 0);
    #1; rst = 1'b0;
    repeat (2) step();
    chk("final_drained", cq.size() + fq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
